// File: rtl/haru_axis_pkg.sv
// Shared AXI4-Stream beat-tag definitions for the HARU stream adapters.
// A beat tag carries the packet framing (first/last) alongside each data word.
package haru_axis_pkg;

    // Depth of the register buffer that absorbs the FIFO read latency.
    localparam int BUF_DEPTH = 2;
    localparam int OCC_WIDTH = $clog2(BUF_DEPTH + 1);

    // Bit positions of the framing flags inside a packed beat tag.
    localparam int TAG_FIRST = 1;
    localparam int TAG_LAST  = 0;

    typedef struct packed {
        logic first;
        logic last;
    } beat_tag_t;

    localparam beat_tag_t TAG_NONE = '{first: 1'b0, last: 1'b0};

    // Build a tag from individual flags, placing them at the agreed bit positions.
    function automatic beat_tag_t make_tag(input logic first, input logic last);
        beat_tag_t tag;
        tag            = TAG_NONE;
        tag[TAG_FIRST] = first;
        tag[TAG_LAST]  = last;
        return tag;
    endfunction

endpackage

// File: rtl/fifo_2_axis_adapter_if.sv
// FIFO read port plus AXI4-Stream master bus of the FIFO->AXIS adapter.
// master: the adapter side (issues reads, drives the stream).
// slave : the environment side (FIFO read data/status, stream sink ready).
interface fifo_2_axis_adapter_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_r_stb;
    logic                  fifo_not_empty;
    logic                  axis_tuser;
    logic                  axis_tvalid;
    logic                  axis_tready;
    logic                  axis_tlast;
    logic [DATA_WIDTH-1:0] axis_tdata;

    modport master (
        input  fifo_data,
        input  fifo_not_empty,
        input  axis_tready,
        output fifo_r_stb,
        output axis_tuser,
        output axis_tvalid,
        output axis_tlast,
        output axis_tdata
    );

    modport slave (
        output fifo_data,
        output fifo_not_empty,
        output axis_tready,
        input  fifo_r_stb,
        input  axis_tuser,
        input  axis_tvalid,
        input  axis_tlast,
        input  axis_tdata
    );
endinterface

// File: rtl/axis_skid_buf_2.sv
// Two-entry register FIFO of {tag, data}. The head entry drives the stream
// directly, so the visible beat stays stable until it is popped.
module axis_skid_buf_2
    import haru_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  beat_tag_t             push_tag_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [OCC_WIDTH-1:0]  occupancy_o,
    output logic                  valid_o,
    output beat_tag_t             head_tag_o,
    output logic [DATA_WIDTH-1:0] head_data_o
);

    typedef struct packed {
        beat_tag_t             tag;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    localparam logic [OCC_WIDTH-1:0] OCC_FULL = OCC_WIDTH'(BUF_DEPTH);
    localparam logic [OCC_WIDTH-1:0] OCC_ONE  = OCC_WIDTH'(1);

    entry_t               head_q, head_d;
    entry_t               tail_q, tail_d;
    entry_t               push_entry;
    logic [OCC_WIDTH-1:0] occ_q, occ_d;
    logic                 pop_ok;
    logic                 push_ok;

    assign push_entry = '{tag: push_tag_i, data: push_data_i};
    assign pop_ok     = pop_i & (occ_q != '0);
    // A push into a full buffer is only accepted when the head leaves the same cycle.
    assign push_ok    = push_i & ((occ_q != OCC_FULL) | pop_ok);

    // Next state: shift toward the head on pop, fill the first free slot on push.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_ok, pop_ok})
            2'b10: begin
                if (occ_q == '0) begin
                    head_d = push_entry;
                end else begin
                    tail_d = push_entry;
                end
                occ_d = occ_q + OCC_ONE;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - OCC_ONE;
            end
            2'b11: begin
                if (occ_q == OCC_ONE) begin
                    head_d = push_entry;
                end else begin
                    head_d = tail_q;
                    tail_d = push_entry;
                end
            end
            default: begin
            end
        endcase
    end

    // Buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is reset too, so the data output reads zero straight out of reset.
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occupancy_o = occ_q;
    assign valid_o     = (occ_q != '0);
    assign head_tag_o  = head_q.tag;
    assign head_data_o = head_q.data;

endmodule

// File: rtl/fifo_2_axis_adapter.sv
// FIFO -> AXI4-Stream read adapter.
// Drains a synchronous FIFO with one cycle of read latency and presents the
// words as an AXI4-Stream master, framed into packets of a programmable beat
// count (tuser on the first beat, tlast on the last). Reads are issued so that
// buffered plus in-flight words never exceed the 2-entry register buffer, which
// still sustains one beat per clock under continuous tready.
// Reset asserts asynchronously; its release is expected to be synchronous to clk.
// Optional build macro FIFO_2_AXIS_STATS_EN adds o_packet_count and o_underrun.
module fifo_2_axis_adapter
    import haru_axis_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COUNT_WIDTH-1:0] i_packet_size,
`ifdef FIFO_2_AXIS_STATS_EN
    output logic [31:0]            o_packet_count,
    output logic                   o_underrun,
`endif
    fifo_2_axis_adapter_if.master  bus
);

    if (FIFO_DATA_WIDTH != AXIS_DATA_WIDTH) begin : g_width_check
        $error("fifo_2_axis_adapter: FIFO_DATA_WIDTH must equal AXIS_DATA_WIDTH");
    end

    localparam int                     FILL_WIDTH = OCC_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0]     idx_q, idx_d;
    logic [COUNT_WIDTH-1:0]     size_q, size_d;
    logic [COUNT_WIDTH-1:0]     eff_size;
    logic                       inflight_q;
    beat_tag_t                  inflight_tag_q;
    beat_tag_t                  issue_tag;
    logic                       issue_first;
    logic                       issue_last;
    logic [OCC_WIDTH-1:0]       occupancy;
    logic                       buf_valid;
    beat_tag_t                  head_tag;
    logic [AXIS_DATA_WIDTH-1:0] head_data;
    logic                       pop;
    logic                       r_stb;
    logic [FILL_WIDTH-1:0]      fill_after_pop;

    assign pop = buf_valid & bus.axis_tready;

    // Read issue: only request a word if it will have a buffer slot when it lands.
    always_comb begin
        fill_after_pop = FILL_WIDTH'(occupancy) + FILL_WIDTH'(inflight_q) - FILL_WIDTH'(pop);
        r_stb          = !rst & bus.fifo_not_empty & (fill_after_pop < FILL_WIDTH'(BUF_DEPTH));
    end

    // Tagging at issue: the packet size is latched on the first read of each packet.
    always_comb begin
        eff_size = size_q;
        if (idx_q == '0) begin
            eff_size = (i_packet_size == '0) ? CNT_ONE : i_packet_size;
        end
        issue_first = (idx_q == '0);
        issue_last  = (idx_q == eff_size - CNT_ONE);
        issue_tag   = make_tag(issue_first, issue_last);
        idx_d       = idx_q;
        size_d      = size_q;
        if (r_stb) begin
            idx_d = issue_last ? '0 : idx_q + CNT_ONE;
            if (issue_first) begin
                size_d = eff_size;
            end
        end
    end

    // Beat counter, latched size and the in-flight read with its tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q          <= '0;
            size_q         <= '0;
            inflight_q     <= 1'b0;
            inflight_tag_q <= TAG_NONE;
        end else begin
            idx_q          <= idx_d;
            size_q         <= size_d;
            inflight_q     <= r_stb;
            inflight_tag_q <= issue_tag;
        end
    end

    axis_skid_buf_2 #(
        .DATA_WIDTH (AXIS_DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_tag_i  (inflight_tag_q),
        .push_data_i (bus.fifo_data),
        .pop_i       (pop),
        .occupancy_o (occupancy),
        .valid_o     (buf_valid),
        .head_tag_o  (head_tag),
        .head_data_o (head_data)
    );

    assign bus.fifo_r_stb  = r_stb;
    assign bus.axis_tvalid = buf_valid;
    assign bus.axis_tuser  = buf_valid & head_tag.first;
    assign bus.axis_tlast  = buf_valid & head_tag.last;
    assign bus.axis_tdata  = head_data;

`ifdef FIFO_2_AXIS_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic        in_pkt_q, in_pkt_d;
    logic        underrun_q, underrun_d;

    // Stats: count completed packets; flag a stream gap inside a packet.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        in_pkt_d   = in_pkt_q;
        underrun_d = underrun_q;
        if (pop) begin
            in_pkt_d = !head_tag.last;
            if (head_tag.last) begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
        end
        if (in_pkt_q && !buf_valid) begin
            underrun_d = 1'b1;
        end
    end

    // Stats registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            in_pkt_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            in_pkt_q   <= in_pkt_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_packet_count = pkt_cnt_q;
    assign o_underrun     = underrun_q;
`endif

endmodule

// File: tb/tb_fifo_2_axis_adapter.sv
// Directed bench for fifo_2_axis_adapter: a queue models the 1-cycle-latency
// FIFO, every cycle checks the read-issue rule and stall stability, and each
// scenario task compares the logged beats against hand-computed tables.
module tb_fifo_2_axis_adapter;

    logic        clk;
    logic        rst;
    logic [15:0] packet_size;
`ifdef FIFO_2_AXIS_STATS_EN
    logic [31:0] packet_count;
    logic        underrun;
`endif

    fifo_2_axis_adapter_if #(.DATA_WIDTH(32)) bus ();

    fifo_2_axis_adapter #(
        .AXIS_DATA_WIDTH (32),
        .FIFO_DATA_WIDTH (32),
        .COUNT_WIDTH     (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_packet_size  (packet_size),
`ifdef FIFO_2_AXIS_STATS_EN
        .o_packet_count (packet_count),
        .o_underrun     (underrun),
`endif
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] beat_data[$];
    logic        beat_user[$];
    logic        beat_last[$];
    int          beat_cyc[$];
    int          stb_cyc[$];
    int          cyc, reads, pops;
    logic        prev_stall, prev_user, prev_last;
    logic [31:0] prev_data;

    task automatic clear_log();
        beat_data.delete(); beat_user.delete(); beat_last.delete();
        beat_cyc.delete();  stb_cyc.delete();
        cyc = 0; reads = 0; pops = 0; prev_stall = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.axis_tready = 1'b0; bus.fifo_not_empty = 1'b0; bus.fifo_data = '0;
        fifo_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_log();
    endtask

    // One clock: apply inputs, sample at negedge, emulate FIFO read at posedge.
    task automatic cycle(input logic ready);
        logic        stb, vld, usr, lst, exp_stb, pop_now;
        logic [31:0] dat;
        bus.axis_tready    = ready;
        bus.fifo_not_empty = (fifo_q.size() != 0);
        @(negedge clk);
        stb = bus.fifo_r_stb; vld = bus.axis_tvalid; usr = bus.axis_tuser;
        lst = bus.axis_tlast; dat = bus.axis_tdata;
        pop_now = vld && ready;
        exp_stb = bus.fifo_not_empty && ((reads - pops - int'(pop_now)) < 2);
        n_cmp++;
        if (stb !== exp_stb) begin
            n_err++;
            $display("FAIL rstb_rule cyc %0d: got %b want %b", cyc, stb, exp_stb);
        end
        if (prev_stall) begin
            n_cmp++;
            if ({vld, usr, lst, dat} !== {1'b1, prev_user, prev_last, prev_data}) begin
                n_err++;
                $display("FAIL stall_hold cyc %0d: got v%b u%b l%b %h want v1 u%b l%b %h",
                         cyc, vld, usr, lst, dat, prev_user, prev_last, prev_data);
            end
        end
        if (pop_now) begin
            beat_data.push_back(dat); beat_user.push_back(usr);
            beat_last.push_back(lst); beat_cyc.push_back(cyc);
            pops++;
        end
        prev_stall = vld && !ready;
        prev_user = usr; prev_last = lst; prev_data = dat;
        if (stb === 1'b1) begin
            stb_cyc.push_back(cyc);
            reads++;
        end
        @(posedge clk);
        #1;
        if (stb === 1'b1 && fifo_q.size() != 0) bus.fifo_data = fifo_q.pop_front();
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.axis_tready = 1'b0; bus.fifo_not_empty = 1'b0; bus.fifo_data = '0;
        packet_size = 16'd4;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.fifo_r_stb, bus.axis_tvalid, bus.axis_tuser, bus.axis_tlast, bus.axis_tdata} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got stb%b v%b u%b l%b %h want all 0", bus.fifo_r_stb,
                     bus.axis_tvalid, bus.axis_tuser, bus.axis_tlast, bus.axis_tdata);
        end
`ifdef FIFO_2_AXIS_STATS_EN
        n_cmp++;
        if ({packet_count, underrun} !== 33'h0) begin
            n_err++;
            $display("FAIL reset_stats: got cnt %0d und %b want 0 0", packet_count, underrun);
        end
`endif
    endtask

    task automatic test_stream();
        apply_reset();
        packet_size = 16'd4;
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'hA0 + 32'(i));
        for (int i = 0; i < 14; i++) cycle(1'b1);
        n_cmp++;
        if (stb_cyc.size() != 8) begin
            n_err++; $display("FAIL t1_stb_count: got %0d want 8", stb_cyc.size());
        end
        n_cmp++;
        if (beat_data.size() != 8) begin
            n_err++; $display("FAIL t1_beat_count: got %0d want 8", beat_data.size());
        end
        for (int i = 0; i < 8 && i < stb_cyc.size(); i++) begin
            n_cmp++;
            if (stb_cyc[i] != i) begin
                n_err++; $display("FAIL t1_stb_cyc[%0d]: got %0d want %0d", i, stb_cyc[i], i);
            end
        end
        for (int i = 0; i < 8 && i < beat_data.size(); i++) begin
            n_cmp++;
            if ({beat_cyc[i], beat_data[i], beat_user[i], beat_last[i]} !==
                {i + 2, 32'hA0 + 32'(i), (i % 4) == 0, (i % 4) == 3}) begin
                n_err++;
                $display("FAIL t1_beat[%0d]: got cyc%0d %h u%b l%b want cyc%0d %h u%b l%b", i,
                         beat_cyc[i], beat_data[i], beat_user[i], beat_last[i],
                         i + 2, 32'hA0 + 32'(i), (i % 4) == 0, (i % 4) == 3);
            end
        end
`ifdef FIFO_2_AXIS_STATS_EN
        n_cmp++;
        if ({packet_count, underrun} !== {32'd2, 1'b0}) begin
            n_err++; $display("FAIL t1_stats: got cnt %0d und %b want 2 0", packet_count, underrun);
        end
`endif
    endtask

    task automatic test_backpressure();
        apply_reset();
        packet_size = 16'd3;
        for (int i = 0; i < 9; i++) fifo_q.push_back(32'hB0 + 32'(i));
        for (int i = 0; i < 30; i++) cycle((i % 2) == 0);
        n_cmp++;
        if (beat_data.size() != 9) begin
            n_err++; $display("FAIL t2_beat_count: got %0d want 9", beat_data.size());
        end
        for (int i = 0; i < 9 && i < beat_data.size(); i++) begin
            n_cmp++;
            if ({beat_data[i], beat_user[i], beat_last[i]} !== {32'hB0 + 32'(i), (i % 3) == 0, (i % 3) == 2}) begin
                n_err++;
                $display("FAIL t2_beat[%0d]: got %h u%b l%b want %h u%b l%b", i, beat_data[i],
                         beat_user[i], beat_last[i], 32'hB0 + 32'(i), (i % 3) == 0, (i % 3) == 2);
            end
        end
    endtask

    task automatic test_fifo_gap();
        logic exp_u[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic exp_l[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        packet_size = 16'd4;
        fifo_q.push_back(32'h30); fifo_q.push_back(32'h31);
        for (int i = 0; i < 9; i++) cycle(1'b1);
        n_cmp++;
        if (beat_data.size() != 2 || bus.axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL t3_gap: got beats %0d tvalid %b want 2 0", beat_data.size(), bus.axis_tvalid);
        end
        fifo_q.push_back(32'h32); fifo_q.push_back(32'h33);
        for (int i = 0; i < 6; i++) cycle(1'b1);
        n_cmp++;
        if (beat_data.size() != 4) begin
            n_err++; $display("FAIL t3_beat_count: got %0d want 4", beat_data.size());
        end
        for (int i = 0; i < 4 && i < beat_data.size(); i++) begin
            n_cmp++;
            if ({beat_data[i], beat_user[i], beat_last[i]} !== {32'h30 + 32'(i), exp_u[i], exp_l[i]}) begin
                n_err++;
                $display("FAIL t3_beat[%0d]: got %h u%b l%b want %h u%b l%b", i, beat_data[i],
                         beat_user[i], beat_last[i], 32'h30 + 32'(i), exp_u[i], exp_l[i]);
            end
        end
`ifdef FIFO_2_AXIS_STATS_EN
        n_cmp++;
        if ({packet_count, underrun} !== {32'd1, 1'b1}) begin
            n_err++; $display("FAIL t3_stats: got cnt %0d und %b want 1 1", packet_count, underrun);
        end
`endif
    endtask

    task automatic test_packet_size();
        logic exp_u[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic exp_l[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        packet_size = 16'd0;
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'hC0 + 32'(i));
        for (int i = 0; i < 7; i++) cycle(1'b1);
        packet_size = 16'd1;
        for (int i = 3; i < 6; i++) fifo_q.push_back(32'hC0 + 32'(i));
        for (int i = 0; i < 7; i++) cycle(1'b1);
        n_cmp++;
        if (beat_data.size() != 6) begin
            n_err++; $display("FAIL t4_small_count: got %0d want 6", beat_data.size());
        end
        for (int i = 0; i < 6 && i < beat_data.size(); i++) begin
            n_cmp++;
            if ({beat_data[i], beat_user[i], beat_last[i]} !== {32'hC0 + 32'(i), 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL t4_small[%0d]: got %h u%b l%b want %h u1 l1", i, beat_data[i],
                         beat_user[i], beat_last[i], 32'hC0 + 32'(i));
            end
        end
        apply_reset();
        packet_size = 16'd4;
        for (int i = 0; i < 6; i++) fifo_q.push_back(32'hD0 + 32'(i));
        for (int i = 0; i < 2; i++) cycle(1'b1);
        packet_size = 16'd2;
        for (int i = 0; i < 8; i++) cycle(1'b1);
        n_cmp++;
        if (beat_data.size() != 6) begin
            n_err++; $display("FAIL t4_change_count: got %0d want 6", beat_data.size());
        end
        for (int i = 0; i < 6 && i < beat_data.size(); i++) begin
            n_cmp++;
            if ({beat_data[i], beat_user[i], beat_last[i]} !== {32'hD0 + 32'(i), exp_u[i], exp_l[i]}) begin
                n_err++;
                $display("FAIL t4_change[%0d]: got %h u%b l%b want %h u%b l%b", i, beat_data[i],
                         beat_user[i], beat_last[i], 32'hD0 + 32'(i), exp_u[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic exp_u[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic exp_l[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        packet_size = 16'd4;
        for (int i = 0; i < 7; i++) fifo_q.push_back(32'h50 + 32'(i));
        // Reads of words 0..2 issued, word 0 popped: word 1 buffered, word 2 in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.fifo_r_stb, bus.axis_tvalid, bus.axis_tuser, bus.axis_tlast, bus.axis_tdata} !== 36'h0) begin
            n_err++;
            $display("FAIL t5_reset_outputs: got stb%b v%b u%b l%b %h want all 0", bus.fifo_r_stb,
                     bus.axis_tvalid, bus.axis_tuser, bus.axis_tlast, bus.axis_tdata);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_log();
        for (int i = 0; i < 8; i++) cycle(1'b1);
        n_cmp++;
        if (beat_data.size() != 4) begin
            n_err++; $display("FAIL t5_beat_count: got %0d want 4", beat_data.size());
        end
        for (int i = 0; i < 4 && i < beat_data.size(); i++) begin
            n_cmp++;
            if ({beat_data[i], beat_user[i], beat_last[i]} !== {32'h53 + 32'(i), exp_u[i], exp_l[i]}) begin
                n_err++;
                $display("FAIL t5_beat[%0d]: got %h u%b l%b want %h u%b l%b", i, beat_data[i],
                         beat_user[i], beat_last[i], 32'h53 + 32'(i), exp_u[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_long_stall();
        logic exp_u[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic exp_l[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        packet_size = 16'd4;
        for (int i = 0; i < 5; i++) fifo_q.push_back(32'hE0 + 32'(i));
        for (int i = 0; i < 20; i++) cycle(1'b0);
        n_cmp++;
        if (stb_cyc.size() != 2) begin
            n_err++; $display("FAIL t6_reads: got %0d want 2", stb_cyc.size());
        end
        n_cmp++;
        if ({bus.axis_tvalid, bus.axis_tuser, bus.axis_tdata} !== {1'b1, 1'b1, 32'hE0}) begin
            n_err++;
            $display("FAIL t6_head: got v%b u%b %h want v1 u1 000000e0", bus.axis_tvalid,
                     bus.axis_tuser, bus.axis_tdata);
        end
        for (int i = 0; i < 10; i++) cycle(1'b1);
        n_cmp++;
        if (beat_data.size() != 5) begin
            n_err++; $display("FAIL t6_beat_count: got %0d want 5", beat_data.size());
        end
        for (int i = 0; i < 5 && i < beat_data.size(); i++) begin
            n_cmp++;
            if ({beat_data[i], beat_user[i], beat_last[i]} !== {32'hE0 + 32'(i), exp_u[i], exp_l[i]}) begin
                n_err++;
                $display("FAIL t6_beat[%0d]: got %h u%b l%b want %h u%b l%b", i, beat_data[i],
                         beat_user[i], beat_last[i], 32'hE0 + 32'(i), exp_u[i], exp_l[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_fifo_gap();
        test_packet_size();
        test_mid_reset();
        test_long_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
